// File: rtl/me_pkg.sv
// Shared definitions for the motion-estimation request master.
// Holds the macroblock index width, MV and SAD field widths, the bit layout of
// the 44-bit result word, the FSM state encoding, and the helpers that convert
// a raw search position to a signed motion vector and pack a result word.
package me_pkg;

  localparam int MB_IDX_W    = 8;   // macroblock column/row index width
  localparam int MVEC_HALF_W = 5;   // one raw search-position coordinate
  localparam int MV_W        = 6;   // signed motion-vector component width
  localparam int SAD_W       = 16;
  localparam int RES_W       = 44;

  // res_data = {mb_y, mb_x, mv_x, mv_y, sad}
  localparam int RES_SAD_LSB = 0;
  localparam int RES_MVY_LSB = RES_SAD_LSB + SAD_W;     // 16
  localparam int RES_MVX_LSB = RES_MVY_LSB + MV_W;      // 22
  localparam int RES_MBX_LSB = RES_MVX_LSB + MV_W;      // 28
  localparam int RES_MBY_LSB = RES_MBX_LSB + MB_IDX_W;  // 36

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_ACK,
    ST_RELEASE,
    ST_WAIT_SLOT,
    ST_DONE,
    ST_ERR
  } state_t;

  // Raw position minus the zero-motion offset, 6-bit two's complement,
  // wrapping rather than saturating.
  function automatic logic [MV_W-1:0] mv_conv(input logic [MVEC_HALF_W-1:0] raw,
                                               input logic [MV_W-1:0]        off);
    return {1'b0, raw} - off;
  endfunction

  function automatic logic [RES_W-1:0] pack_res(input logic [MB_IDX_W-1:0]    y,
                                                 input logic [MB_IDX_W-1:0]    x,
                                                 input logic [MVEC_HALF_W-1:0] w,
                                                 input logic [MVEC_HALF_W-1:0] h,
                                                 input logic [SAD_W-1:0]       sad,
                                                 input logic [MV_W-1:0]        off);
    logic [RES_W-1:0] r;
    r = '0;
    r[RES_MBY_LSB +: MB_IDX_W] = y;
    r[RES_MBX_LSB +: MB_IDX_W] = x;
    r[RES_MVX_LSB +: MV_W]     = mv_conv(w, off);
    r[RES_MVY_LSB +: MV_W]     = mv_conv(h, off);
    r[RES_SAD_LSB +: SAD_W]    = sad;
    return r;
  endfunction

endpackage

// File: rtl/me_res_slot.sv
// One-entry valid/ready holding register for result words.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   push        load push_data this cycle (caller guarantees slot free or popping)
//   push_data   word to load
//   flush       drop any held word (valid forced low)
//   ready       downstream accepts the held word
//   valid/data  held word; data is stable while valid and not ready
module me_res_slot #(
  parameter int W = 44
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         flush,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] data
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (valid_q && ready) valid_d = 1'b0;
    // A push in the same cycle as a pop refills the slot.
    if (push) begin
      valid_d = 1'b1;
      data_d  = push_data;
    end
    if (flush) valid_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;

endmodule

// File: rtl/me_req_master.sv
// Initiator side of the ME req/ack four-phase handshake.
// Walks MB_COLS x MB_ROWS macroblocks; for each one raises me_req, waits for
// me_ack (bounded by TIMEOUT cycles), captures SAD and motion vector, drops
// me_req, and forwards one packed result word on a valid/ready stream.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   start                     begins a frame when idle
//   busy, frame_done          frame in progress / one-cycle completion pulse
//   timeout_err               sticky ack-timeout flag (cleared only by rst)
//   mb_x, mb_y                macroblock currently requested
//   me_req, me_ack            handshake with ME control
//   me_min_sad, me_min_mvec   result from ME control, valid while ack high
//   res_valid, res_ready      result stream handshake
//   res_data                  {mb_y, mb_x, mv_x, mv_y, sad}
module me_req_master
  import me_pkg::*;
#(
  parameter int MB_COLS   = 22,
  parameter int MB_ROWS   = 18,
  parameter int MV_OFFSET = 19,
  parameter int TIMEOUT   = 2048
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 timeout_err,
  output logic [MB_IDX_W-1:0]  mb_x,
  output logic [MB_IDX_W-1:0]  mb_y,
  output logic                 me_req,
  input  logic                 me_ack,
  input  logic [SAD_W-1:0]     me_min_sad,
  input  logic [9:0]           me_min_mvec,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [RES_W-1:0]     res_data
);

  localparam int CNT_W = ($clog2(TIMEOUT) < 1) ? 1 : $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [MB_IDX_W-1:0] X_LAST   = MB_IDX_W'(MB_COLS - 1);
  localparam logic [MB_IDX_W-1:0] Y_LAST   = MB_IDX_W'(MB_ROWS - 1);
  localparam logic [MV_W-1:0]     MV_OFF   = MV_W'(MV_OFFSET);

  state_t               state_q, state_d;
  logic                 me_req_q, me_req_d;
  logic                 busy_q, busy_d;
  logic                 frame_done_q, frame_done_d;
  logic                 timeout_err_q, timeout_err_d;
  logic [MB_IDX_W-1:0]  mb_x_q, mb_x_d;
  logic [MB_IDX_W-1:0]  mb_y_q, mb_y_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [RES_W-1:0]     cap_q, cap_d;
  // Captured result not yet moved into the output slot.
  logic                 pend_q, pend_d;

  logic slot_push, slot_flush, slot_free, last_mb;

  assign last_mb   = (mb_x_q == X_LAST) && (mb_y_q == Y_LAST);
  assign slot_free = !res_valid || res_ready;

  always_comb begin
    state_d       = state_q;
    me_req_d      = me_req_q;
    busy_d        = busy_q;
    frame_done_d  = 1'b0;
    timeout_err_d = timeout_err_q;
    mb_x_d        = mb_x_q;
    mb_y_d        = mb_y_q;
    cnt_d         = cnt_q;
    cap_d         = cap_q;
    pend_d        = pend_q;
    slot_push     = 1'b0;
    slot_flush    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mb_x_d  = '0;
          mb_y_d  = '0;
          busy_d  = 1'b1;
          state_d = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        // Never raise req while the previous ack is still high.
        if (!me_ack) begin
          me_req_d = 1'b1;
          cnt_d    = '0;
          state_d  = ST_WAIT_ACK;
        end
      end

      ST_WAIT_ACK: begin
        // Ack has priority over the timeout in the same cycle.
        if (me_ack) begin
          cap_d    = pack_res(mb_y_q, mb_x_q, me_min_mvec[9:5], me_min_mvec[4:0],
                              me_min_sad, MV_OFF);
          me_req_d = 1'b0;
          state_d  = ST_RELEASE;
        end else if (cnt_q == CNT_LAST) begin
          me_req_d      = 1'b0;
          timeout_err_d = 1'b1;
          slot_flush    = 1'b1;
          state_d       = ST_ERR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_RELEASE: begin
        me_req_d = 1'b0;
        if (!me_ack) begin
          if (slot_free) begin
            slot_push = 1'b1;
            if (last_mb) begin
              state_d = ST_WAIT_SLOT;
            end else begin
              state_d = ST_ISSUE;
              if (mb_x_q == X_LAST) begin
                mb_x_d = '0;
                mb_y_d = mb_y_q + MB_IDX_W'(1);
              end else begin
                mb_x_d = mb_x_q + MB_IDX_W'(1);
              end
            end
          end else begin
            pend_d  = 1'b1;
            state_d = ST_WAIT_SLOT;
          end
        end
      end

      ST_WAIT_SLOT: begin
        if (pend_q) begin
          if (slot_free) begin
            slot_push = 1'b1;
            pend_d    = 1'b0;
            // Last macroblock stays here until its word is accepted.
            if (!last_mb) begin
              state_d = ST_ISSUE;
              if (mb_x_q == X_LAST) begin
                mb_x_d = '0;
                mb_y_d = mb_y_q + MB_IDX_W'(1);
              end else begin
                mb_x_d = mb_x_q + MB_IDX_W'(1);
              end
            end
          end
        end else if (res_valid && res_ready) begin
          // Nothing pending: the held word is the frame's last result.
          frame_done_d = 1'b1;
          state_d      = ST_DONE;
        end
      end

      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      ST_ERR: begin
        me_req_d   = 1'b0;
        slot_flush = 1'b1;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      me_req_q      <= 1'b0;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      timeout_err_q <= 1'b0;
      mb_x_q        <= '0;
      mb_y_q        <= '0;
      cnt_q         <= '0;
      cap_q         <= '0;
      pend_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      me_req_q      <= me_req_d;
      busy_q        <= busy_d;
      frame_done_q  <= frame_done_d;
      timeout_err_q <= timeout_err_d;
      mb_x_q        <= mb_x_d;
      mb_y_q        <= mb_y_d;
      cnt_q         <= cnt_d;
      cap_q         <= cap_d;
      pend_q        <= pend_d;
    end
  end

  me_res_slot #(.W(RES_W)) u_slot (
    .clk       (clk),
    .rst       (rst),
    .push      (slot_push),
    .push_data (cap_q),
    .flush     (slot_flush),
    .ready     (res_ready),
    .valid     (res_valid),
    .data      (res_data)
  );

  assign me_req      = me_req_q;
  assign busy        = busy_q;
  assign frame_done  = frame_done_q;
  assign timeout_err = timeout_err_q;
  assign mb_x        = mb_x_q;
  assign mb_y        = mb_y_q;

endmodule
